// File: rtl/kernel_bank.sv
// Double-buffered bank of KSIZE x KSIZE signed convolution kernels with per-kernel shift.
// A selection is staged tap-by-tap into a shadow and swapped in atomically on frame_start.
module kernel_bank #(
  parameter int KSIZE     = 3,
  parameter int COEF_W    = 6,
  parameter int N_KERNELS = 8,
  parameter int SEL_W     = 3,
  parameter int TAP_W     = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            sel_strobe,
  input  logic                            frame_start,
  input  logic                            wr_en,
  input  logic [SEL_W-1:0]                wr_kernel,
  input  logic [TAP_W-1:0]                wr_tap,
  input  logic [COEF_W-1:0]               wr_data,
  output logic                            wr_ready,
  output logic [KSIZE*KSIZE*COEF_W-1:0]   kernel,
  output logic [3:0]                      norm_shift,
  output logic [SEL_W-1:0]                active_sel,
  output logic                            kernel_update,
  output logic                            busy
);
  localparam int TAPS = KSIZE * KSIZE;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ARMED = 2'd2} state_t;

  localparam int DFLT [8][9] = '{
    '{ 0,  0,  0,  0,  1,  0,  0,  0,  0},
    '{ 1,  1,  1,  1,  1,  1,  1,  1,  1},
    '{ 1,  2,  1,  2,  4,  2,  1,  2,  1},
    '{ 0, -1,  0, -1,  5, -1,  0, -1,  0},
    '{-1,  0,  1, -2,  0,  2, -1,  0,  1},
    '{-1, -2, -1,  0,  0,  0,  1,  2,  1},
    '{ 0,  1,  0,  1, -4,  1,  0,  1,  0},
    '{-2, -1,  0, -1,  1,  1,  0,  1,  2}
  };

  function automatic logic [COEF_W-1:0] dflt_coef(input int k, input int t);
    int v;
    v = (t == TAPS / 2) ? 1 : 0;
    if (KSIZE == 3 && k < 8) begin
      v = DFLT[k][t];
    end
    return COEF_W'(v);
  endfunction

  function automatic logic [3:0] dflt_shift(input int k);
    logic [3:0] s;
    s = 4'd0;
    if (KSIZE == 3 && k == 1) s = 4'd3;
    if (KSIZE == 3 && k == 2) s = 4'd4;
    return s;
  endfunction

  logic [COEF_W-1:0]      coef_q   [N_KERNELS][TAPS];
  logic [COEF_W-1:0]      coef_d   [N_KERNELS][TAPS];
  logic [3:0]             shift_q  [N_KERNELS];
  logic [3:0]             shift_d  [N_KERNELS];
  logic [COEF_W-1:0]      shadow_q [TAPS];
  logic [COEF_W-1:0]      shadow_d [TAPS];
  logic [3:0]             shadow_shift_q, shadow_shift_d;
  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       pend_sel_q, pend_sel_d;
  logic [TAP_W-1:0]       cnt_q, cnt_d;
  logic [TAPS*COEF_W-1:0] kernel_q, kernel_d;
  logic [3:0]             norm_shift_q, norm_shift_d;
  logic [SEL_W-1:0]       active_sel_q, active_sel_d;
  logic                   kernel_update_q, kernel_update_d;
  logic                   busy_q, busy_d;
  logic                   wr_ready_q, wr_ready_d;

  logic                   sel_ok, wr_ok;
  logic [COEF_W-1:0]      src_coef [TAPS];
  logic [3:0]             src_shift;

  // Next-state logic: write port, staging FSM and frame-boundary swap.
  always_comb begin
    coef_d          = coef_q;
    shift_d         = shift_q;
    shadow_d        = shadow_q;
    shadow_shift_d  = shadow_shift_q;
    state_d         = state_q;
    pend_sel_d      = pend_sel_q;
    cnt_d           = cnt_q;
    kernel_d        = kernel_q;
    norm_shift_d    = norm_shift_q;
    active_sel_d    = active_sel_q;
    kernel_update_d = 1'b0;
    src_shift       = 4'd0;
    for (int t = 0; t < TAPS; t++) src_coef[t] = '0;

    sel_ok = ({1'b0, sel} < (SEL_W + 1)'(N_KERNELS));
    wr_ok  = wr_en && wr_ready_q && ({1'b0, wr_kernel} < (SEL_W + 1)'(N_KERNELS))
             && (wr_tap <= TAP_W'(TAPS));

    for (int k = 0; k < N_KERNELS; k++) begin
      if (wr_ok && wr_kernel == SEL_W'(k)) begin
        for (int t = 0; t < TAPS; t++) begin
          if (wr_tap == TAP_W'(t)) coef_d[k][t] = wr_data;
        end
        if (wr_tap == TAP_W'(TAPS)) shift_d[k] = wr_data[3:0];
      end
      if (pend_sel_q == SEL_W'(k)) begin
        src_coef  = coef_q[k];
        src_shift = shift_q[k];
      end
    end

    case (state_q)
      IDLE: begin
        if (sel_strobe && sel_ok) begin
          state_d    = LOAD;
          pend_sel_d = sel;
          cnt_d      = '0;
        end
      end
      LOAD: begin
        if (sel_strobe && sel_ok) begin
          pend_sel_d = sel;
          cnt_d      = '0;
        end else begin
          for (int t = 0; t < TAPS; t++) begin
            if (cnt_q == TAP_W'(t)) shadow_d[t] = src_coef[t];
          end
          if (cnt_q == TAP_W'(TAPS - 1)) begin
            shadow_shift_d = src_shift;
            state_d        = ARMED;
          end else begin
            cnt_d = cnt_q + TAP_W'(1);
          end
        end
      end
      ARMED: begin
        // A new request beats a coincident frame boundary.
        if (sel_strobe && sel_ok) begin
          state_d    = LOAD;
          pend_sel_d = sel;
          cnt_d      = '0;
        end else if (frame_start) begin
          state_d = IDLE;
          for (int t = 0; t < TAPS; t++) begin
            kernel_d[(TAPS-1-t)*COEF_W +: COEF_W] = shadow_q[t];
          end
          norm_shift_d    = shadow_shift_q;
          active_sel_d    = pend_sel_q;
          kernel_update_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    wr_ready_d = (state_d != LOAD);
  end

  // State and output registers with synchronous reset to the default bank.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < N_KERNELS; k++) begin
        for (int t = 0; t < TAPS; t++) coef_q[k][t] <= dflt_coef(k, t);
        shift_q[k] <= dflt_shift(k);
      end
      for (int t = 0; t < TAPS; t++) begin
        shadow_q[t] <= '0;
        kernel_q[(TAPS-1-t)*COEF_W +: COEF_W] <= dflt_coef(0, t);
      end
      shadow_shift_q  <= 4'd0;
      state_q         <= IDLE;
      pend_sel_q      <= '0;
      cnt_q           <= '0;
      norm_shift_q    <= 4'd0;
      active_sel_q    <= '0;
      kernel_update_q <= 1'b0;
      busy_q          <= 1'b0;
      wr_ready_q      <= 1'b1;
    end else begin
      coef_q          <= coef_d;
      shift_q         <= shift_d;
      shadow_q        <= shadow_d;
      shadow_shift_q  <= shadow_shift_d;
      state_q         <= state_d;
      pend_sel_q      <= pend_sel_d;
      cnt_q           <= cnt_d;
      kernel_q        <= kernel_d;
      norm_shift_q    <= norm_shift_d;
      active_sel_q    <= active_sel_d;
      kernel_update_q <= kernel_update_d;
      busy_q          <= busy_d;
      wr_ready_q      <= wr_ready_d;
    end
  end

  assign kernel        = kernel_q;
  assign norm_shift    = norm_shift_q;
  assign active_sel    = active_sel_q;
  assign kernel_update = kernel_update_q;
  assign busy          = busy_q;
  assign wr_ready      = wr_ready_q;

endmodule

// File: tb/tb_kernel_bank.sv
// Scoreboard bench for kernel_bank: expected swaps are queued when frame_start is driven
// and checked by a monitor when kernel_update fires; tasks check control outputs inline.
module tb_kernel_bank;
  typedef struct {
    logic [53:0] k;
    logic [3:0]  s;
    logic [2:0]  a;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        sel_strobe = 1'b0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_kernel = 3'd0;
  logic [3:0]  wr_tap = 4'd0;
  logic [5:0]  wr_data = 6'd0;
  logic        wr_ready;
  logic [53:0] kernel;
  logic [3:0]  norm_shift;
  logic [2:0]  active_sel;
  logic        kernel_update;
  logic        busy;

  logic [2:0]  sel6 = 3'd0;
  logic        strobe6 = 1'b0;
  logic        wr_ready6;
  logic [53:0] kernel6;
  logic [3:0]  norm_shift6;
  logic [2:0]  active_sel6;
  logic        kernel_update6;
  logic        busy6;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t pend_exp;

  logic [5:0] mcoef [8][9];
  logic [3:0] mshift [8];

  int dk [8][9] = '{
    '{ 0,  0,  0,  0,  1,  0,  0,  0,  0},
    '{ 1,  1,  1,  1,  1,  1,  1,  1,  1},
    '{ 1,  2,  1,  2,  4,  2,  1,  2,  1},
    '{ 0, -1,  0, -1,  5, -1,  0, -1,  0},
    '{-1,  0,  1, -2,  0,  2, -1,  0,  1},
    '{-1, -2, -1,  0,  0,  0,  1,  2,  1},
    '{ 0,  1,  0,  1, -4,  1,  0,  1,  0},
    '{-2, -1,  0, -1,  1,  1,  0,  1,  2}
  };
  int ds [8] = '{0, 3, 4, 0, 0, 0, 0, 0};

  kernel_bank u_dut (
    .clk(clk), .resetn(resetn), .sel(sel), .sel_strobe(sel_strobe),
    .frame_start(frame_start), .wr_en(wr_en), .wr_kernel(wr_kernel),
    .wr_tap(wr_tap), .wr_data(wr_data), .wr_ready(wr_ready), .kernel(kernel),
    .norm_shift(norm_shift), .active_sel(active_sel),
    .kernel_update(kernel_update), .busy(busy)
  );

  kernel_bank #(.N_KERNELS(6)) u_dut6 (
    .clk(clk), .resetn(resetn), .sel(sel6), .sel_strobe(strobe6),
    .frame_start(1'b0), .wr_en(1'b0), .wr_kernel(3'd0),
    .wr_tap(4'd0), .wr_data(6'd0), .wr_ready(wr_ready6), .kernel(kernel6),
    .norm_shift(norm_shift6), .active_sel(active_sel6),
    .kernel_update(kernel_update6), .busy(busy6)
  );

  always #5 clk = ~clk;

  function automatic logic [53:0] pack(input int k);
    logic [53:0] p;
    for (int t = 0; t < 9; t++) p[(8-t)*6 +: 6] = mcoef[k][t];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < 9; t++) mcoef[k][t] = 6'(dk[k][t]);
      mshift[k] = 4'(ds[k]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int s);
    @(negedge clk);
    sel = 3'(s);
    sel_strobe = 1'b1;
    pend_exp.k = pack(s);
    pend_exp.s = mshift[s];
    pend_exp.a = 3'(s);
    @(negedge clk);
    sel_strobe = 1'b0;
  endtask

  task automatic frame_pulse(input bit push);
    @(negedge clk);
    frame_start = 1'b1;
    if (push) exp_q.push_back(pend_exp);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic write(input int k, input int t, input logic [5:0] d, input bit accept);
    @(negedge clk);
    wr_en = 1'b1;
    wr_kernel = 3'(k);
    wr_tap = 4'(t);
    wr_data = d;
    if (accept) begin
      if (t < 9) mcoef[k][t] = d;
      else mshift[k] = d[3:0];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Scoreboard: every kernel_update must match the oldest queued swap.
  always @(negedge clk) begin
    if (resetn && kernel_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL update_unexpected got kernel=%h active_sel=%0d, none expected", kernel, active_sel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (kernel !== e.k) begin
          bad++;
          $display("FAIL swap_kernel got=%h exp=%h", kernel, e.k);
        end
        total++;
        if (norm_shift !== e.s) begin
          bad++;
          $display("FAIL swap_shift got=%0d exp=%0d", norm_shift, e.s);
        end
        total++;
        if (active_sel !== e.a) begin
          bad++;
          $display("FAIL swap_sel got=%0d exp=%0d", active_sel, e.a);
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    step(3);
    resetn = 1'b1;
    model_reset();
    step(1);
    total++;
    if (kernel !== pack(0)) begin bad++; $display("FAIL reset_kernel got=%h exp=%h", kernel, pack(0)); end
    total++;
    if (active_sel !== 3'd0 || norm_shift !== 4'd0) begin
      bad++; $display("FAIL reset_sel_shift got=%0d/%0d exp=0/0", active_sel, norm_shift);
    end
    total++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_busy_ready got=%b/%b exp=0/1", busy, wr_ready);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      total++;
      if (kernel_update !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL idle_quiet got upd=%b busy=%b exp=0/0", kernel_update, busy);
      end
    end
    frame_pulse(1'b0);
    total++;
    if (kernel_update !== 1'b0) begin bad++; $display("FAIL idle_frame got=%b exp=0", kernel_update); end
  endtask

  task automatic test_select_gaussian();
    strobe(2);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b exp=1", busy); end
    step(4);
    frame_pulse(1'b0);
    total++;
    if (kernel_update !== 1'b0 || active_sel !== 3'd0) begin
      bad++; $display("FAIL load_frame_ignored got upd=%b sel=%0d exp=0/0", kernel_update, active_sel);
    end
    step(2);
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL load_last got wr_ready=%b exp=0", wr_ready); end
    step(1);
    total++;
    if (wr_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL armed got wr_ready=%b busy=%b exp=1/1", wr_ready, busy);
    end
    frame_pulse(1'b1);
    total++;
    if (busy !== 1'b0 || kernel_update !== 1'b1) begin
      bad++; $display("FAIL swap_done got busy=%b upd=%b exp=0/1", busy, kernel_update);
    end
    step(1);
    total++;
    if (kernel_update !== 1'b0) begin bad++; $display("FAIL upd_one_cycle got=%b exp=0", kernel_update); end
  endtask

  task automatic test_strobe_beats_frame();
    strobe(4);
    step(9);
    @(negedge clk);
    sel = 3'd6;
    sel_strobe = 1'b1;
    frame_start = 1'b1;
    pend_exp.k = pack(6);
    pend_exp.s = mshift[6];
    pend_exp.a = 3'd6;
    @(negedge clk);
    sel_strobe = 1'b0;
    frame_start = 1'b0;
    total++;
    if (kernel_update !== 1'b0 || active_sel !== 3'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL strobe_wins got upd=%b sel=%0d busy=%b exp=0/2/1", kernel_update, active_sel, busy);
    end
    step(9);
    frame_pulse(1'b1);
    total++;
    if (kernel[24 +: 6] !== 6'b111100) begin bad++; $display("FAIL lap_centre got=%b exp=111100", kernel[24 +: 6]); end
  endtask

  task automatic test_back_to_back();
    strobe(1);
    step(3);
    strobe(0);
    step(8);
    total++;
    if (wr_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_load got wr_ready=%b busy=%b exp=0/1", wr_ready, busy);
    end
    step(1);
    frame_pulse(1'b1);
  endtask

  task automatic test_write_idle();
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", wr_ready); end
    write(3, 4, 6'b111101, 1'b1);
    write(3, 9, 6'd2, 1'b1);
    strobe(3);
    step(9);
    frame_pulse(1'b1);
    total++;
    if (kernel[24 +: 6] !== 6'b111101 || norm_shift !== 4'd2) begin
      bad++; $display("FAIL edit_k3 got centre=%b shift=%0d exp=111101/2", kernel[24 +: 6], norm_shift);
    end
  endtask

  task automatic test_write_blocked();
    strobe(5);
    step(1);
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL load_not_ready got=%b exp=0", wr_ready); end
    write(5, 8, 6'd7, 1'b0);
    step(7);
    write(5, 4, 6'd9, 1'b1);
    frame_pulse(1'b1);
    strobe(5);
    step(9);
    frame_pulse(1'b1);
    @(negedge clk);
    sel6 = 3'd7;
    strobe6 = 1'b1;
    @(negedge clk);
    strobe6 = 1'b0;
    step(2);
    total++;
    if (busy6 !== 1'b0) begin bad++; $display("FAIL bad_sel_ignored got busy=%b exp=0", busy6); end
    @(negedge clk);
    sel6 = 3'd5;
    strobe6 = 1'b1;
    @(negedge clk);
    strobe6 = 1'b0;
    total++;
    if (busy6 !== 1'b1) begin bad++; $display("FAIL good_sel_n6 got busy=%b exp=1", busy6); end
  endtask

  task automatic test_reset_armed();
    write(2, 0, 6'd5, 1'b1);
    strobe(2);
    step(9);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL pre_reset_armed got=%b exp=1", busy); end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    total++;
    if (kernel !== pack(0) || busy !== 1'b0 || active_sel !== 3'd0 || norm_shift !== 4'd0) begin
      bad++; $display("FAIL mid_reset got kernel=%h busy=%b sel=%0d shift=%0d exp=%h/0/0/0",
                      kernel, busy, active_sel, norm_shift, pack(0));
    end
    strobe(2);
    step(9);
    frame_pulse(1'b1);
  endtask

  initial begin
    test_reset();
    test_select_gaussian();
    test_strobe_beats_frame();
    test_back_to_back();
    test_write_idle();
    test_write_blocked();
    test_reset_armed();
    step(3);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL swaps_missing got=%0d pending exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
